// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA sync/blanking timing generator with a two-stage pattern pipeline.
//   Stage 0 holds the pixel counters (cx, cy), the bar tracker and the
//   frame-latched mode. Stage 1 registers the decoded timing and pattern
//   indices. Stage 2 registers the pins. Every output therefore lags the
//   counters by exactly two clocks, and all outputs stay aligned.
//
//   Optional feature macro: VGA_PATTERN_SCROLL_EN
//     defined   : a 10-bit offset advances once per frame, and the
//                 spectrum and checkerboard patterns scroll diagonally.
//     undefined : offset is constant zero and no register is built.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   mode         in   0 spectrum, 1 colour bars, 2 checkerboard, 3 solid.
//                     The new value takes effect at the next frame start.
//   solid_color  in   {R,G,B} colour used in mode 3, sampled per pixel
//   hs, vs       out  syncs, with the active level set by HS_POL / VS_POL
//   de           out  display enable (active area)
//   rgb          out  {R,G,B}, forced to zero whenever de=0
//   frame_start  out  one-cycle pulse aligned with output pixel (0,0)
//
//   The outputs are free-running: a new pixel is presented on every clock.
//   There is no valid/ready handshake; de marks the visible pixels.
//   Requires H_ACTIVE >= 8, CHK_LOG2 <= 9 and 1 <= CW <= 8.

module vga_pattern_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 4,
    parameter int CHK_LOG2 = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] solid_color,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic [3*CW-1:0] rgb,
    output logic            frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(H_ACTIVE / 8 - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // ---------------- stage 0: counters, bar tracker, mode latch ----------------
    logic [10:0] cx_q, cx_d;
    logic [9:0]  cy_q, cy_d;
    logic [2:0]  bar_q, bar_d;
    logic [10:0] bar_cnt_q, bar_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [9:0]  offset;
    logic        line_wrap, frame_wrap;

    always_comb begin
        line_wrap  = (cx_q == H_LAST);
        frame_wrap = line_wrap && (cy_q == V_LAST);
        cx_d       = line_wrap ? 11'd0 : cx_q + 11'd1;
        cy_d       = cy_q;
        if (line_wrap) begin
            cy_d = (cy_q == V_LAST) ? 10'd0 : cy_q + 10'd1;
        end
        mode_d = frame_wrap ? mode : mode_q;

        // The bar index follows cx without a divider. The last bar never
        // advances, so it absorbs any remainder of H_ACTIVE/8.
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q + 11'd1;
        if (line_wrap) begin
            bar_d     = 3'd0;
            bar_cnt_d = 11'd0;
        end else if (bar_cnt_q == BAR_LAST && bar_q != 3'd7) begin
            bar_d     = bar_q + 3'd1;
            bar_cnt_d = 11'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q      <= '0;
            cy_q      <= '0;
            bar_q     <= '0;
            bar_cnt_q <= '0;
            mode_q    <= '0;
        end else begin
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
            mode_q    <= mode_d;
        end
    end

`ifdef VGA_PATTERN_SCROLL_EN
    logic [9:0] offset_q, offset_d;

    always_comb begin
        offset_d = offset_q;
        if (frame_wrap) begin
            offset_d = offset_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) offset_q <= '0;
        else     offset_q <= offset_d;
    end

    assign offset = offset_q;
`else
    assign offset = '0;
`endif

    // Only the bits that feed a pattern are formed. The low bits of a sum
    // depend only on the low bits of its operands, so the checker bits can
    // be taken from narrow adds.
    logic [CHK_LOG2:0] px_low, py_low;
    logic [6:0]        py_hi;

    assign px_low = cx_q[CHK_LOG2:0] + offset[CHK_LOG2:0];
    assign py_low = cy_q[CHK_LOG2:0] + offset[CHK_LOG2:0];
    assign py_hi  = 7'((cy_q + offset) >> 3);

    // ---------------- stage 1: decoded timing and pattern indices ----------------
    logic       s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
    logic       s1_fs_q, s1_fs_d, s1_chk_q, s1_chk_d;
    logic [1:0] s1_mode_q, s1_mode_d;
    logic [2:0] s1_band_q, s1_band_d, s1_bar_q, s1_bar_d;
    logic [3:0] s1_shade_q, s1_shade_d;

    always_comb begin
        s1_hs_d    = (cx_q >= HS_START) && (cx_q < HS_END);
        s1_vs_d    = (cy_q >= VS_START) && (cy_q < VS_END);
        s1_de_d    = (cx_q < H_ACT) && (cy_q < V_ACT);
        s1_fs_d    = (cx_q == 11'd0) && (cy_q == 10'd0);
        s1_chk_d   = px_low[CHK_LOG2] ^ py_low[CHK_LOG2];
        s1_mode_d  = mode_q;
        s1_band_d  = py_hi[6:4];
        s1_shade_d = py_hi[3:0];
        s1_bar_d   = bar_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_de_q    <= 1'b0;
            s1_fs_q    <= 1'b0;
            s1_chk_q   <= 1'b0;
            s1_mode_q  <= '0;
            s1_band_q  <= '0;
            s1_shade_q <= '0;
            s1_bar_q   <= '0;
        end else begin
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_de_q    <= s1_de_d;
            s1_fs_q    <= s1_fs_d;
            s1_chk_q   <= s1_chk_d;
            s1_mode_q  <= s1_mode_d;
            s1_band_q  <= s1_band_d;
            s1_shade_q <= s1_shade_d;
            s1_bar_q   <= s1_bar_d;
        end
    end

    // ---------------- stage 2: colour generation and pin registers ----------------
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [3*CW-1:0] rgb_q, rgb_d;
    logic [7:0]      shade8;
    logic [CW-1:0]   sh, ff, zz;

    always_comb begin
        // Shade is MSB-aligned into CW bits (truncated or zero-padded).
        shade8 = {s1_shade_q, 4'b0000};
        sh     = shade8[7 -: CW];
        ff     = '1;
        zz     = '0;
        rgb_d  = '0;
        unique case (s1_mode_q)
            2'd0: begin
                case (s1_band_q)
                    3'd0:    rgb_d = {ff, sh, zz};
                    3'd1:    rgb_d = {~sh, ff, zz};
                    3'd2:    rgb_d = {zz, ff, sh};
                    3'd3:    rgb_d = {zz, ~sh, ff};
                    3'd4:    rgb_d = {sh, zz, ff};
                    3'd5:    rgb_d = {ff, zz, ~sh};
                    default: rgb_d = {ff, ff, ff};
                endcase
            end
            2'd1: begin
                case (s1_bar_q)
                    3'd0:    rgb_d = {ff, ff, ff};
                    3'd1:    rgb_d = {ff, ff, zz};
                    3'd2:    rgb_d = {zz, ff, ff};
                    3'd3:    rgb_d = {zz, ff, zz};
                    3'd4:    rgb_d = {ff, zz, ff};
                    3'd5:    rgb_d = {ff, zz, zz};
                    3'd6:    rgb_d = {zz, zz, ff};
                    default: rgb_d = {zz, zz, zz};
                endcase
            end
            2'd2:    rgb_d = s1_chk_q ? {ff, ff, ff} : {zz, zz, zz};
            default: rgb_d = solid_color;
        endcase
        if (!s1_de_q) begin
            rgb_d = '0;
        end
        hs_d = s1_hs_q ? HS_POL : ~HS_POL;
        vs_d = s1_vs_q ? VS_POL : ~VS_POL;
        de_d = s1_de_q;
        fs_d = s1_fs_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            fs_q  <= fs_d;
            rgb_q <= rgb_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen. A narrow line (22 clocks) keeps a full
// 806-line frame short enough to run four frames. The full 768-line height
// is kept so that every spectrum band appears. A model process pushes one
// expected pixel per clock into exp_q. A monitor pops the queue and
// compares once the two-stage pipeline latency has elapsed. Directed
// hand-computed colours are also checked at chosen pixels.
`timescale 1ns/1ps
module tb_vga_pattern_gen;
    localparam int HA = 18, HFP = 1, HSY = 2, HBP = 1;
    localparam int VA = 768, VFP = 3, VSY = 6, VBP = 29;
    localparam int CHK = 2;
    localparam int HT = HA + HFP + HSY + HBP;   // 22
    localparam int VT = VA + VFP + VSY + VBP;   // 806
`ifdef VGA_PATTERN_SCROLL_EN
    localparam int DIR_N = 21;
`else
    localparam int DIR_N = 25;
`endif
    localparam logic [11:0] BAR_TAB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_color = 12'h3A5;
    logic        hs, vs, de, frame_start;
    logic [11:0] rgb;

    typedef struct packed {
        logic [1:0]  frame;
        logic        phase;
        logic [10:0] cx;
        logic [9:0]  cy;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dir_hits = 0;
    int   ecx = 0, ecy = 0, eframe = 0;
    logic [1:0] emode = 2'd0;
    logic [9:0] eoff = 10'd0;
    logic       phase = 1'b0;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .CHK_LOG2(CHK)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .solid_color(solid_color),
        .hs(hs), .vs(vs), .de(de), .rgb(rgb), .frame_start(frame_start)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic exp_t model_pixel(input int x, input int y, input int f,
                                         input logic [1:0] m, input logic [9:0] off,
                                         input logic ph, input logic [11:0] sc);
        exp_t e;
        int px, py, band, bar;
        logic [3:0] sh;
        e.frame = 2'(f);
        e.phase = ph;
        e.cx    = 11'(x);
        e.cy    = 10'(y);
        e.hs    = !(x >= HA + HFP && x < HA + HFP + HSY);
        e.vs    = !(y >= VA + VFP && y < VA + VFP + VSY);
        e.de    = (x < HA) && (y < VA);
        e.fs    = (x == 0) && (y == 0);
        e.rgb   = 12'h000;
        px = (x + int'(off)) % 2048;
        py = (y + int'(off)) % 1024;
        if (e.de) begin
            case (m)
                2'd0: begin
                    band = (py >> 7) & 7;
                    sh   = 4'((py >> 3) & 15);
                    case (band)
                        0:       e.rgb = {4'hF, sh, 4'h0};
                        1:       e.rgb = {~sh, 4'hF, 4'h0};
                        2:       e.rgb = {4'h0, 4'hF, sh};
                        3:       e.rgb = {4'h0, ~sh, 4'hF};
                        4:       e.rgb = {sh, 4'h0, 4'hF};
                        5:       e.rgb = {4'hF, 4'h0, ~sh};
                        default: e.rgb = 12'hFFF;
                    endcase
                end
                2'd1: begin
                    bar = x / (HA / 8);
                    if (bar > 7) bar = 7;
                    e.rgb = BAR_TAB[bar];
                end
                2'd2:    e.rgb = ((((px >> CHK) ^ (py >> CHK)) & 1) != 0) ? 12'hFFF : 12'h000;
                default: e.rgb = sc;
            endcase
        end
        return e;
    endfunction

    // Hand-computed colours at selected pixels, keyed on {frame, cy, cx}.
    function automatic bit dir_want(input exp_t e, output logic [11:0] want);
        bit hit = 1'b1;
        want = 12'h000;
        case ({e.frame, e.cy, e.cx})
            // frame 0: spectrum
            {2'd0, 10'd0,   11'd7}:  want = 12'hF00;  // band 0, shade 0
            {2'd0, 10'd119, 11'd0}:  want = 12'hFE0;  // band 0, shade E
            {2'd0, 10'd127, 11'd0}:  want = 12'hFF0;  // band 0, shade F
            {2'd0, 10'd128, 11'd0}:  want = 12'hFF0;  // band 1, shade 0
            {2'd0, 10'd150, 11'd5}:  want = 12'hDF0;  // band 1, shade 2, after the mode write
            {2'd0, 10'd200, 11'd3}:  want = 12'h6F0;  // band 1, shade 9
            {2'd0, 10'd767, 11'd17}: want = 12'hF00;  // band 5, shade F, last active pixel
            {2'd0, 10'd10,  11'd18}: want = 12'h000;  // horizontal blanking
            {2'd0, 10'd790, 11'd2}:  want = 12'h000;  // vertical blanking
            // frame 1: bars, width 2, with the last bar spanning cx 14..17
            {2'd1, 10'd0,   11'd0}:  want = 12'hFFF;
            {2'd1, 10'd0,   11'd2}:  want = 12'hFF0;
            {2'd1, 10'd0,   11'd4}:  want = 12'h0FF;
            {2'd1, 10'd0,   11'd6}:  want = 12'h0F0;
            {2'd1, 10'd0,   11'd8}:  want = 12'hF0F;
            {2'd1, 10'd0,   11'd10}: want = 12'hF00;
            {2'd1, 10'd0,   11'd12}: want = 12'h00F;
            {2'd1, 10'd0,   11'd14}: want = 12'h000;
            {2'd1, 10'd0,   11'd17}: want = 12'h000;
            {2'd1, 10'd300, 11'd1}:  want = 12'hFFF;
`ifndef VGA_PATTERN_SCROLL_EN
            // frame 2: checkerboard with a 4-pixel cell
            {2'd2, 10'd0,   11'd4}:  want = 12'hFFF;
            {2'd2, 10'd4,   11'd4}:  want = 12'h000;
            {2'd2, 10'd4,   11'd0}:  want = 12'hFFF;
            {2'd2, 10'd0,   11'd0}:  want = 12'h000;
`endif
            // frame 3: solid
            {2'd3, 10'd0,   11'd0}:  want = 12'h3A5;
            {2'd3, 10'd50,  11'd17}: want = 12'h3A5;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst) begin
                ecx = 0; ecy = 0; eframe = 0; emode = 2'd0; eoff = 10'd0;
                exp_q.delete();
            end else begin
                e = model_pixel(ecx, ecy, eframe, emode, eoff, phase, solid_color);
                exp_q.push_back(e);
                if (ecx == HT - 1) begin
                    ecx = 0;
                    if (ecy == VT - 1) begin
                        ecy = 0;
                        eframe++;
                        emode = mode;
`ifdef VGA_PATTERN_SCROLL_EN
                        eoff = eoff + 10'd1;
`endif
                    end else begin
                        ecy++;
                    end
                end else begin
                    ecx++;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        exp_t e;
        logic [11:0] want;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 1) begin
                e = exp_q.pop_front();
                checks++;
                if (hs !== e.hs || vs !== e.vs || de !== e.de ||
                    frame_start !== e.fs || rgb !== e.rgb) begin
                    errors++;
                    $display("FAIL pixel f%0d cy=%0d cx=%0d got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=%b vs=%b de=%b fs=%b rgb=%h",
                             e.frame, e.cy, e.cx, hs, vs, de, frame_start, rgb,
                             e.hs, e.vs, e.de, e.fs, e.rgb);
                end
                if (!e.phase && dir_want(e, want)) begin
                    dir_hits++;
                    checks++;
                    if (rgb !== want) begin
                        errors++;
                        $display("FAIL directed f%0d cy=%0d cx=%0d got rgb=%h want %h",
                                 e.frame, e.cy, e.cx, rgb, want);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset(input string name);
        checks++;
        if (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0 || frame_start !== 1'b0 || rgb !== 12'h000) begin
            errors++;
            $display("FAIL %s got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=1 vs=1 de=0 fs=0 rgb=000",
                     name, hs, vs, de, frame_start, rgb);
        end
    endtask

    task automatic wait_pos(input int f, input int y);
        int n = 0;
        while (!(eframe == f && ecy == y) && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!(eframe == f && ecy == y)) begin
            errors++;
            $display("FAIL wait_pos got frame=%0d line=%0d want frame=%0d line=%0d",
                     eframe, ecy, f, y);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (5) begin
            @(negedge clk);
            check_reset("rst_hold");
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Each mode write lands mid-frame and must wait for the next frame.
        wait_pos(0, 100); mode = 2'd1;
        wait_pos(1, 100); mode = 2'd2;
        wait_pos(2, 100); mode = 2'd3;
        wait_pos(3, 100);

        // Mid-frame reset: the outputs must be at their reset values after
        // one edge, and the next frame restarts in spectrum mode.
        rst   = 1'b1;
        phase = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);

        checks++;
        if (dir_hits != DIR_N) begin
            errors++;
            $display("FAIL directed_coverage got %0d want %0d", dir_hits, DIR_N);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
